// File: rtl/bytes2packets_packer_if.sv
// bytes2packets_packer_if: Avalon-ST data/valid/ready bundle.
// master drives data/valid; slave returns ready.
interface bytes2packets_packer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/bytes2packets_packer.sv
// bytes2packets_packer: packs bytes into BPW-byte words framed as WPP-word packets.
// Define BYTES2PACKETS_FLUSH_EN for early packet flush and the empty output.
module bytes2packets_packer #(
    parameter int BYTES_PER_WORD   = 4,
    parameter int WORDS_PER_PACKET = 64,
    parameter int EMPTY_W =
        (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
    input  logic                    clock_clk,
    input  logic                    reset_reset_n,
    bytes2packets_packer_if.slave   asi_in0,
    bytes2packets_packer_if.master  aso_out0,
    output logic                    aso_out0_startofpacket,
    output logic                    aso_out0_endofpacket,
    output logic [EMPTY_W-1:0]      aso_out0_empty,
    input  logic                    flush
);
    localparam int BPW = BYTES_PER_WORD;
    localparam int WPP = WORDS_PER_PACKET;
    localparam int DW  = 8 * BPW;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WCW = (WPP > 1) ? $clog2(WPP) : 1;
    localparam logic [BCW-1:0] LAST_B = BCW'(BPW - 1);
    localparam logic [WCW-1:0] LAST_W = WCW'(WPP - 1);
    localparam logic [EMPTY_W-1:0] PAD_EMPTY = EMPTY_W'(BPW - 1);

    logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]     word_cnt_q, word_cnt_d;
    logic [DW-1:0]      asm_q, asm_d;
    logic [DW-1:0]      dat_q, dat_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [EMPTY_W-1:0] emp_q, emp_d;
    logic               vld_q, vld_d;
    logic               pend_q, pend_d;

    logic          slot_free;
    logic          in_rdy;
    logic          take;
    logic          last_b;
    logic          last_w;
    logic          flush_req;
    logic [5:0]    sh;
    logic [DW-1:0] merged;

    assign slot_free = !vld_q || aso_out0.ready;
    assign in_rdy    = reset_reset_n && !pend_q &&
                       (byte_cnt_q != LAST_B || slot_free);
    assign take      = asi_in0.valid && in_rdy;
    assign last_b    = byte_cnt_q == LAST_B;
    assign last_w    = word_cnt_q == LAST_W;
    // first byte of a word lands in the most significant lane
    assign sh        = 6'(8 * (BPW - 1 - int'(byte_cnt_q)));
    assign merged    = asm_q | (DW'(asi_in0.data) << sh);

`ifdef BYTES2PACKETS_FLUSH_EN
    assign flush_req = flush &&
                       (byte_cnt_q != '0 || word_cnt_q != '0);
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_req    = 1'b0;
`endif

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        dat_d      = dat_q;
        sop_d      = sop_q;
        eop_d      = eop_q;
        emp_d      = emp_q;
        vld_d      = vld_q;
        pend_d     = pend_q;

        if (vld_q && aso_out0.ready)
            vld_d = 1'b0;

        if (take && last_b) begin
            dat_d      = merged;
            sop_d      = word_cnt_q == '0;
            eop_d      = last_w || flush_req;
            emp_d      = '0;
            vld_d      = 1'b1;
            asm_d      = '0;
            byte_cnt_d = '0;
            word_cnt_d = (last_w || flush_req) ?
                         '0 : word_cnt_q + 1'b1;
        end else begin
            if (take) begin
                asm_d      = merged;
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
            if (flush_req)
                pend_d = 1'b1;
        end

`ifdef BYTES2PACKETS_FLUSH_EN
        // short word or single pad byte closes the open packet
        if (pend_q && slot_free) begin
            vld_d = 1'b1;
            sop_d = word_cnt_q == '0;
            eop_d = 1'b1;
            if (byte_cnt_q == '0) begin
                dat_d = '0;
                emp_d = PAD_EMPTY;
            end else begin
                dat_d = asm_q;
                emp_d = EMPTY_W'(BPW - int'(byte_cnt_q));
            end
            asm_d      = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            pend_d     = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            dat_q      <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            emp_q      <= '0;
            vld_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            dat_q      <= dat_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            emp_q      <= emp_d;
            vld_q      <= vld_d;
            pend_q     <= pend_d;
        end
    end

    assign asi_in0.ready          = in_rdy;
    assign aso_out0.data          = dat_q;
    assign aso_out0.valid         = vld_q;
    assign aso_out0_startofpacket = sop_q;
    assign aso_out0_endofpacket   = eop_q;
    assign aso_out0_empty         = emp_q;
endmodule
